// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, runs the memory read handshake and issues words to the decoder.
// Optional FETCH_COUNT_EN adds a saturating count of issued instructions on fetch_count.
module instruction_fetch_unit #(
    parameter int                 ADDR_W    = 7,
    parameter int                 INST_W    = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC  = '0,
    parameter logic [INST_W-1:0]  HALT_WORD = 32'hFFFF_FFFF,
    parameter int                 TIMEOUT   = 15
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    input  logic [INST_W-1:0] mem_data,
    input  logic              mem_did_read,
    output logic [INST_W-1:0] inst_out,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              branch_valid,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] pc_out,
    output logic              halted,
`ifdef FETCH_COUNT_EN
    output logic [15:0]       fetch_count,
`endif
    output logic              fetch_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_REQ,
        S_WAIT,
        S_ISSUE,
        S_HALT,
        S_ERR
    } state_t;

    state_t             state, state_nx;
    logic [ADDR_W-1:0]  pc, pc_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic               capture;
    logic               handshake;

    assign mem_addr = pc;
    assign pc_out   = pc;

    // NOTE: every variable gets a default at the top so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_nx  = state;
        pc_nx     = pc;
        cnt_nx    = cnt;
        capture   = 1'b0;
        handshake = 1'b0;

        case (state)
            S_REQ: begin
                // A did_read seen here may still belong to the previous address.
                state_nx = S_WAIT;
                cnt_nx   = '0;
            end
            S_WAIT: begin
                if (mem_did_read) begin
                    capture  = 1'b1;
                    cnt_nx   = '0;
                    state_nx = (mem_data == HALT_WORD) ? S_HALT : S_ISSUE;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_nx = S_ERR;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            S_ISSUE: begin
                if (inst_ready) begin
                    handshake = 1'b1;
                    pc_nx     = pc + ADDR_W'(1);
                    state_nx  = S_REQ;
                end
            end
            default: ;
        endcase

        // Redirect wins over everything above; a capture in the same cycle is dropped.
        if (branch_valid && (state == S_REQ || state == S_WAIT || state == S_ISSUE)) begin
            pc_nx    = branch_target;
            cnt_nx   = '0;
            capture  = 1'b0;
            state_nx = S_REQ;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            cnt        <= '0;
            mem_en     <= 1'b0;
            inst_out   <= '0;
            inst_valid <= 1'b0;
            halted     <= 1'b0;
            fetch_err  <= 1'b0;
        end else begin
            state      <= state_nx;
            pc         <= pc_nx;
            cnt        <= cnt_nx;
            mem_en     <= (state_nx == S_REQ) || (state_nx == S_WAIT);
            inst_valid <= (state_nx == S_ISSUE);
            halted     <= (state_nx == S_HALT);
            fetch_err  <= (state_nx == S_ERR);
            if (capture) begin
                inst_out <= mem_data;
            end
        end
    end

`ifdef FETCH_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_count <= '0;
        end else if (handshake && fetch_count != 16'hFFFF) begin
            fetch_count <= fetch_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: program run, stall, branch, PC wrap, timeout and async reset.
// Instance b uses RESET_PC=127 to exercise the PC wrap.
module tb_instruction_fetch_unit;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;

    logic [6:0]  a_addr, a_bt, a_pc;
    logic        a_en, a_did, a_valid, a_ready, a_bv, a_halted, a_err, a_block;
    logic [31:0] a_data, a_inst;

    logic [6:0]  b_addr, b_pc;
    logic        b_en, b_did, b_valid, b_halted, b_err;
    logic [31:0] b_data, b_inst;
    logic        b_ready = 1'b1;
    logic        b_bv = 1'b0;
    logic [6:0]  b_bt = 7'd0;

`ifdef FETCH_COUNT_EN
    logic [15:0] a_count, b_count;
`endif

    logic [31:0] mem [0:127];

    int n_vec = 0;
    int n_bad = 0;

    instruction_fetch_unit u_a (
        .clk          (clk),
        .reset        (reset),
        .mem_addr     (a_addr),
        .mem_en       (a_en),
        .mem_data     (a_data),
        .mem_did_read (a_did),
        .inst_out     (a_inst),
        .inst_valid   (a_valid),
        .inst_ready   (a_ready),
        .branch_valid (a_bv),
        .branch_target(a_bt),
        .pc_out       (a_pc),
        .halted       (a_halted),
`ifdef FETCH_COUNT_EN
        .fetch_count  (a_count),
`endif
        .fetch_err    (a_err)
    );

    instruction_fetch_unit #(.RESET_PC(7'd127)) u_b (
        .clk          (clk),
        .reset        (reset),
        .mem_addr     (b_addr),
        .mem_en       (b_en),
        .mem_data     (b_data),
        .mem_did_read (b_did),
        .inst_out     (b_inst),
        .inst_valid   (b_valid),
        .inst_ready   (b_ready),
        .branch_valid (b_bv),
        .branch_target(b_bt),
        .pc_out       (b_pc),
        .halted       (b_halted),
`ifdef FETCH_COUNT_EN
        .fetch_count  (b_count),
`endif
        .fetch_err    (b_err)
    );

    // Memory answers on the falling edge whenever enabled, unless blocked.
    always @(negedge clk) begin
        a_did  <= a_en && !a_block;
        a_data <= mem[a_addr];
        b_did  <= b_en;
        b_data <= mem[b_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        a_bv  = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    logic [31:0] got_inst [$];
    logic [6:0]  got_pc [$];
    logic [31:0] exp_inst [0:4];
    int          halt_issued;
    bit          b_seen, b_pending, found;

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        mem[0]   = 32'h01020001;
        mem[1]   = 32'h02030200;
        mem[2]   = 32'h040403FF;
        mem[3]   = 32'h0307042A;
        mem[4]   = 32'h05050704;
        mem[5]   = HALT;
        mem[127] = 32'h01020001;
        for (int i = 0; i < 5; i++) exp_inst[i] = mem[i];

        a_ready = 1'b1;
        a_block = 1'b0;
        a_bv    = 1'b0;
        a_bt    = 7'd0;
        reset   = 1'b1;

        // ---- reset state and straight-line program ----
        #2;
        check("rst_mem_en",  a_en, 0);
        check("rst_valid",   a_valid, 0);
        check("rst_pc",      a_pc, 0);
        check("rst_inst",    a_inst, 0);
        check("rst_halted",  a_halted, 0);
        check("rst_err",     a_err, 0);
        check("rst_b_pc",    b_pc, 127);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        halt_issued = 0;
        b_seen = 0;
        b_pending = 0;
        for (int cyc = 0; cyc < 60 && !a_halted; cyc++) begin
            @(posedge clk);
            #1;
            if (a_valid) begin
                got_inst.push_back(a_inst);
                got_pc.push_back(a_pc);
                if (a_inst == HALT) halt_issued++;
            end
            if (b_pending) begin
                check("b_wrap_addr", b_addr, 0);
                b_pending = 0;
            end
            if (b_valid && !b_seen) begin
                check("b_first_pc",   b_pc, 127);
                check("b_first_inst", b_inst, 32'h01020001);
                b_seen = 1;
                b_pending = 1;
            end
        end
        check("prog_halted",     a_halted, 1);
        check("prog_halt_pc",    a_pc, 5);
        check("prog_halt_en",    a_en, 0);
        check("prog_halt_valid", a_valid, 0);
        check("prog_halt_issue", halt_issued, 0);
        check("prog_count",      got_inst.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("prog_inst%0d", i), (i < got_inst.size()) ? got_inst[i] : 32'hX, exp_inst[i]);
            check($sformatf("prog_pc%0d", i),   (i < got_pc.size())   ? got_pc[i]   : 7'hX,  i);
        end
        check("b_seen", b_seen, 1);
`ifdef FETCH_COUNT_EN
        check("prog_fetch_count", a_count, 5);
`endif

        // ---- decoder stall on word 1 ----
        apply_reset();
        found = 0;
        for (int cyc = 0; cyc < 30 && !found; cyc++) begin
            @(posedge clk);
            #1;
            if (a_valid && a_pc == 7'd1) found = 1;
        end
        check("stall_reach", found, 1);
        a_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("stall_valid", a_valid, 1);
            check("stall_inst",  a_inst, 32'h02030200);
            check("stall_pc",    a_pc, 1);
            check("stall_en",    a_en, 0);
        end
        a_ready = 1'b1;
        @(posedge clk);
        #1;
        check("stall_adv_pc",    a_pc, 2);
        check("stall_adv_valid", a_valid, 0);
        check("stall_adv_en",    a_en, 1);

        // ---- branch during WAIT of address 1 ----
        apply_reset();
        found = 0;
        for (int cyc = 0; cyc < 30 && !found; cyc++) begin
            @(posedge clk);
            #1;
            if (a_pc == 7'd1 && a_en && !a_valid) found = 1;
        end
        check("br_reach", found, 1);
        @(posedge clk);
        #1;
        a_bv = 1'b1;
        a_bt = 7'd4;
        @(posedge clk);
        #1;
        a_bv = 1'b0;
        check("br_pc",      a_pc, 4);
        check("br_valid",   a_valid, 0);
        check("br_discard", a_inst, 32'h01020001);
        found = 0;
        for (int cyc = 0; cyc < 20 && !found; cyc++) begin
            @(posedge clk);
            #1;
            if (a_valid) found = 1;
        end
        check("br_issue",      found, 1);
        check("br_issue_inst", a_inst, 32'h05050704);
        check("br_issue_pc",   a_pc, 4);

        // ---- read timeout ----
        a_block = 1'b1;
        apply_reset();
        repeat (15) @(posedge clk);
        #1;
        check("to_pre_err", a_err, 0);
        check("to_pre_en",  a_en, 1);
        @(posedge clk);
        #1;
        check("to_err",   a_err, 1);
        check("to_en",    a_en, 0);
        check("to_valid", a_valid, 0);
        check("to_pc",    a_pc, 0);
        a_bv = 1'b1;
        a_bt = 7'd3;
        @(posedge clk);
        #1;
        a_bv = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("to_br_pc",  a_pc, 0);
        check("to_br_err", a_err, 1);
        check("to_br_en",  a_en, 0);

        // ---- async reset in the middle of a WAIT at address 3 ----
        a_block = 1'b0;
        apply_reset();
        found = 0;
        for (int cyc = 0; cyc < 40 && !found; cyc++) begin
            @(posedge clk);
            #1;
            if (a_pc == 7'd3 && a_en && !a_valid) found = 1;
        end
        check("ar_reach", found, 1);
        a_block = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("ar_en",    a_en, 0);
        check("ar_valid", a_valid, 0);
        check("ar_pc",    a_pc, 0);
        check("ar_inst",  a_inst, 0);
`ifdef FETCH_COUNT_EN
        check("ar_fetch_count", a_count, 0);
`endif
        a_block = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        found = 0;
        for (int cyc = 0; cyc < 20 && !found; cyc++) begin
            @(posedge clk);
            #1;
            if (a_valid) found = 1;
        end
        check("ar_restart",      found, 1);
        check("ar_restart_pc",   a_pc, 0);
        check("ar_restart_inst", a_inst, 32'h01020001);

        // ---- instance b runs 127, 0..4 and halts on address 5 ----
        for (int cyc = 0; cyc < 80 && !b_halted; cyc++) begin
            @(posedge clk);
            #1;
        end
        check("b_halted", b_halted, 1);
        check("b_halt_pc", b_pc, 5);
        check("b_err",    b_err, 0);
`ifdef FETCH_COUNT_EN
        check("b_fetch_count", b_count, 6);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Initiator side of the instruction-memory read protocol; lives in the execution engine.
- Holds the program counter and drives the memory address and enable lines.
- Waits for the memory's read-done flag, captures the 32-bit word and presents it to the decoder with a valid/ready handshake.
- Handles branch redirect, halt-word detection and read timeout.

Parameters:
ADDR_W, 7, instruction address width; the PC wraps modulo 2^ADDR_W
INST_W, 32, instruction word width
RESET_PC, 0, PC value after reset
HALT_WORD, 32'hFFFF_FFFF, instruction word that stops fetching
TIMEOUT, 15, max WAIT cycles without mem_did_read before error

Ports:
clk  input  1  clock; all state changes on rising edge
reset  input  1  reset, asynchronous, active-high
mem_addr  output  ADDR_W  instruction memory address (= PC)
mem_en  output  1  instruction memory enable
mem_data  input  INST_W  instruction word from memory
mem_did_read  input  1  memory read-done flag (memory updates it on falling edge)
inst_out  output  INST_W  captured instruction to decoder
inst_valid  output  1  inst_out valid
inst_ready  input  1  decoder accepts inst_out
branch_valid  input  1  redirect request, single-cycle
branch_target  input  ADDR_W  redirect address
pc_out  output  ADDR_W  address of instruction in inst_out or being fetched
halted  output  1  HALT_WORD fetched; sticky until reset
fetch_err  output  1  read timeout; sticky until reset

Behaviour:
- Reset (async, any state, mid-transfer included):
  - PC=RESET_PC, state=REQ, mem_en=0, inst_out=0, inst_valid=0, halted=0, fetch_err=0, timeout counter=0.
  - In-flight reads are abandoned and their data is ignored.
- mem_addr = PC at all times; mem_en is a registered output.
- Reset deassertion: first rising edge after deassertion enters REQ, with mem_en going high that edge.
- REQ (1 cycle):
  - mem_en=1, mem_did_read ignored (it may be stale from the previous address).
  - Next state WAIT.
- WAIT:
  - mem_en=1; counter increments each cycle.
  - mem_did_read=1 at a rising edge: inst_out<=mem_data, mem_en<=0, counter cleared.
  - If mem_data==HALT_WORD: go to HALT. Otherwise inst_valid<=1 and go to ISSUE.
  - Counter reaching TIMEOUT with no did_read: go to ERR.
  - Minimum latency from PC change to inst_valid is 2 cycles.
- ISSUE:
  - inst_valid=1 and mem_en=0. inst_out and pc_out are held stable until the handshake.
  - inst_valid && inst_ready at an edge: inst_valid<=0, PC<=PC+1 (wraps 2^ADDR_W-1 -> 0), go to REQ.
- HALT: mem_en=0, inst_valid=0, halted=1; pc_out holds the halt word's address. Only reset exits.
- ERR: mem_en=0, inst_valid=0, fetch_err=1; pc_out holds the failing address. Only reset exits.
- Branch (REQ, WAIT, ISSUE only):
  - branch_valid=1 at an edge: PC<=branch_target, inst_valid<=0, counter cleared, go to REQ.
  - Any pending capture in that same cycle is discarded; halt detection is suppressed for it.
  - In ISSUE with inst_ready=1 in the same cycle, the handshake counts as completed, then the redirect is applied.
  - branch_valid is ignored in HALT and ERR.
- inst_ready while inst_valid=0 has no effect.
- mem_did_read outside WAIT is ignored.

Optional Feature:
- Macro FETCH_COUNT_EN.
- Defined:
  - Adds output fetch_count [15:0], reset 0.
  - Increments by 1 on each completed inst_valid/inst_ready handshake; saturates at 16'hFFFF.
  - Branch-discarded and halt words are not counted.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Memory model holds 01020001, 02030200, 040403FF, 0307042A, 05050704, FFFFFFFF at addresses 0-5; inst_ready tied 1. Required: inst_out sequence 01020001, 02030200, 040403FF, 0307042A, 05050704; then halted=1, pc_out=5, mem_en=0, inst_valid never high with FFFFFFFF.
- Same program, inst_ready held 0 for 5 cycles on word 1. Required: inst_valid=1 with inst_out=02030200 and pc_out=1 stable throughout; mem_en=0; PC advances to 2 only after ready.
- branch_valid with branch_target=4 during WAIT of address 1. Required: the word at address 1 is never issued; next issued inst_out=05050704 with pc_out=4.
- PC=127 (RESET_PC=127 instance), memory returns 01020001. Required: after the handshake, mem_addr=0.
- Memory model never asserts did_read. Required: fetch_err=1 at WAIT cycle 15, mem_en=0; branch_valid then ignored.
- Async reset asserted mid-WAIT at address 3. Required: mem_en=0, inst_valid=0, pc_out=0 immediately; after release, fetch restarts at 0. With FETCH_COUNT_EN, fetch_count=5 after the first test and 0 after reset.
